// File: rtl/sync_mem_unit.sv
// Shared instruction/data memory with a fetch port, a load/store port and a
// boot-load streaming mode. One array access per cycle, one-cycle read latency.
module sync_mem_unit #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  output logic              if_rdy,
  output logic              if_valid,
  output logic [DWIDTH-1:0] if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [AWIDTH-1:0] ls_addr,
  input  logic [DWIDTH-1:0] ls_wdata,
  output logic              ls_rdy,
  output logic              ls_valid,
  output logic [DWIDTH-1:0] ls_rdata,
  output logic              ls_err,
  input  logic              boot_en,
  input  logic              boot_wvalid,
  input  logic [DWIDTH-1:0] boot_wdata,
  output logic [AWIDTH-1:0] boot_cnt,
  output logic              boot_done
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    BOOT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH-1);

  function automatic logic in_range(input logic [AWIDTH-1:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

  logic [DWIDTH-1:0] mem_r [DEPTH];

  state_t            state_r;
  state_t            state_next_s;
  logic              boot_arm_r;
  logic              if_acc_s;
  logic              ls_acc_s;
  logic              boot_we_s;
  logic              boot_entry_s;
  logic              we_s;
  logic [AWIDTH-1:0] waddr_s;
  logic [DWIDTH-1:0] wdata_s;

  // Next-state, arbitration and write-port selection.
  always_comb begin
    state_next_s = state_r;
    ls_rdy       = 1'b0;
    if_rdy       = 1'b0;
    we_s         = 1'b0;
    waddr_s      = ls_addr;
    wdata_s      = ls_wdata;
    boot_we_s    = 1'b0;
    case (state_r)
      RUN: begin
        ls_rdy = 1'b1;
        if_rdy = if_req & ~ls_req;
        if (boot_en && boot_arm_r) begin
          state_next_s = BOOT;
        end else begin
          state_next_s = RUN;
        end
      end
      BOOT: begin
        boot_we_s = boot_wvalid;
        if (!boot_en || (boot_wvalid && (boot_cnt == LAST_ADDR))) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = BOOT;
        end
      end
      FLUSH: begin
        state_next_s = RUN;
      end
      default: begin
        state_next_s = RUN;
      end
    endcase
    if_acc_s     = if_req & if_rdy;
    ls_acc_s     = ls_req & ls_rdy;
    boot_entry_s = (state_r == RUN) && (state_next_s == BOOT);
    if (boot_we_s) begin
      we_s    = 1'b1;
      waddr_s = boot_cnt;
      wdata_s = boot_wdata;
    end else begin
      we_s    = ls_acc_s & ls_we & in_range(ls_addr);
      waddr_s = ls_addr;
      wdata_s = ls_wdata;
    end
  end

  // Single write port into the array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  // FSM state, boot counter and registered read/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      boot_arm_r <= 1'b1;
      boot_cnt   <= {AWIDTH{1'b0}};
      boot_done  <= 1'b0;
      if_valid   <= 1'b0;
      if_data    <= {DWIDTH{1'b0}};
      ls_valid   <= 1'b0;
      ls_rdata   <= {DWIDTH{1'b0}};
      ls_err     <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      boot_done <= (state_next_s == FLUSH);
      // A new boot is only allowed once boot_en has been seen low.
      if (!boot_en) begin
        boot_arm_r <= 1'b1;
      end else if (boot_entry_s) begin
        boot_arm_r <= 1'b0;
      end else begin
        boot_arm_r <= boot_arm_r;
      end
      if (boot_entry_s) begin
        boot_cnt <= {AWIDTH{1'b0}};
      end else if (boot_we_s && (boot_cnt != LAST_ADDR)) begin
        boot_cnt <= boot_cnt + {{(AWIDTH-1){1'b0}}, 1'b1};
      end else begin
        boot_cnt <= boot_cnt;
      end
      if_valid <= if_acc_s;
      if (if_acc_s) begin
        if_data <= in_range(if_addr) ? mem_r[if_addr] : {DWIDTH{1'b0}};
      end else begin
        if_data <= if_data;
      end
      ls_valid <= ls_acc_s & ~ls_we;
      ls_err   <= ls_acc_s & ~in_range(ls_addr);
      if (ls_acc_s && !ls_we) begin
        ls_rdata <= in_range(ls_addr) ? mem_r[ls_addr] : {DWIDTH{1'b0}};
      end else begin
        ls_rdata <= ls_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sync_mem_unit.sv
// Scoreboard bench for sync_mem_unit (DEPTH=200): expected read results are
// queued at accept time and matched against valid/err pulses with latency.
module tb_sync_mem_unit;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DP = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_rdy, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_data;
  logic          ls_req, ls_we, ls_rdy, ls_valid, ls_err;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic          boot_en, boot_wvalid, boot_done;
  logic [DW-1:0] boot_wdata;
  logic [AW-1:0] boot_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          valid;
    logic          err;
    int            due;
  } exp_t;

  exp_t          if_q[$];
  exp_t          ls_q[$];
  logic [DW-1:0] model [256];

  sync_mem_unit #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdy(if_rdy),
    .if_valid(if_valid), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdy(ls_rdy), .ls_valid(ls_valid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .boot_en(boot_en), .boot_wvalid(boot_wvalid), .boot_wdata(boot_wdata),
    .boot_cnt(boot_cnt), .boot_done(boot_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs sampled on the falling edge: retire due results, then log accepts.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (boot_done === 1'b1) done_cnt++;
    if (if_valid === 1'b1) begin
      if (if_q.size() == 0) begin
        check("if_spurious", 32'd1, 32'd0);
      end else begin
        e = if_q.pop_front();
        check("if_latency", cyc, e.due);
        check("if_data", {16'h0, if_data}, {16'h0, e.data});
      end
    end else if (if_q.size() > 0 && if_q[0].due <= cyc) begin
      check("if_missing", 32'd0, 32'd1);
      e = if_q.pop_front();
    end
    if (ls_valid === 1'b1 || ls_err === 1'b1) begin
      if (ls_q.size() == 0) begin
        check("ls_spurious", 32'd1, 32'd0);
      end else begin
        e = ls_q.pop_front();
        check("ls_latency", cyc, e.due);
        check("ls_valid", {31'h0, ls_valid}, {31'h0, e.valid});
        check("ls_err", {31'h0, ls_err}, {31'h0, e.err});
        if (e.valid) check("ls_rdata", {16'h0, ls_rdata}, {16'h0, e.data});
      end
    end else if (ls_q.size() > 0 && ls_q[0].due <= cyc) begin
      check("ls_missing", 32'd0, 32'd1);
      e = ls_q.pop_front();
    end
    if (!rst) begin
      if (if_req && if_rdy) begin
        e.data  = (int'(if_addr) < DP) ? model[if_addr] : 16'h0000;
        e.valid = 1'b1;
        e.err   = 1'b0;
        e.due   = cyc + 1;
        if_q.push_back(e);
      end
      if (ls_req && ls_rdy) begin
        e.due = cyc + 1;
        e.err = (int'(ls_addr) >= DP);
        if (ls_we) begin
          if (int'(ls_addr) < DP) model[ls_addr] = ls_wdata;
          e.valid = 1'b0;
          e.data  = 16'h0000;
          if (e.err) ls_q.push_back(e);
        end else begin
          e.valid = 1'b1;
          e.data  = e.err ? 16'h0000 : model[ls_addr];
          ls_q.push_back(e);
        end
      end
    end
  end

  task automatic ls_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = d;
    tick();
    ls_req = 1'b0; ls_we = 1'b0;
  endtask

  task automatic boot_word(input logic [DW-1:0] d);
    boot_wvalid = 1'b1; boot_wdata = d;
    tick();
    boot_wvalid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] words [4];
    words[0] = 16'h0004; words[1] = 16'h3400; words[2] = 16'h3900; words[3] = 16'hA000;
    rst = 1'b1; if_req = 1'b0; if_addr = 8'd0; ls_req = 1'b0; ls_we = 1'b0;
    ls_addr = 8'd0; ls_wdata = 16'h0; boot_en = 1'b0; boot_wvalid = 1'b0; boot_wdata = 16'h0;

    // Reset state.
    tick(); tick();
    check("rst_if_valid", {31'h0, if_valid}, 32'd0);
    check("rst_ls_valid", {31'h0, ls_valid}, 32'd0);
    check("rst_ls_err", {31'h0, ls_err}, 32'd0);
    check("rst_boot_done", {31'h0, boot_done}, 32'd0);
    check("rst_if_data", {16'h0, if_data}, 32'd0);
    check("rst_ls_rdata", {16'h0, ls_rdata}, 32'd0);
    check("rst_boot_cnt", {24'h0, boot_cnt}, 32'd0);
    rst = 1'b0;

    // Fetch out of range from a fresh array: zero data, one-cycle valid.
    if_req = 1'b1; if_addr = 8'd250;
    #1;
    check("run_if_rdy", {31'h0, if_rdy}, 32'd1);
    check("run_ls_rdy", {31'h0, ls_rdy}, 32'd1);
    tick();
    if_req = 1'b0;
    check("if_pulse_hi", {31'h0, if_valid}, 32'd1);
    tick();
    check("if_pulse_lo", {31'h0, if_valid}, 32'd0);

    // Boot four words with a gap, then drop boot_en.
    boot_en = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 8'd0;
    #1;
    check("boot_if_rdy", {31'h0, if_rdy}, 32'd0);
    check("boot_ls_rdy", {31'h0, ls_rdy}, 32'd0);
    if_req = 1'b0;
    boot_word(words[0]); boot_word(words[1]);
    tick();
    boot_word(words[2]); boot_word(words[3]);
    check("boot_cnt4", {24'h0, boot_cnt}, 32'd4);
    for (int i = 0; i < 4; i++) model[i] = words[i];
    boot_en = 1'b0;
    tick();
    check("boot_done_hi", {31'h0, boot_done}, 32'd1);
    tick();
    check("boot_done_lo", {31'h0, boot_done}, 32'd0);
    check("boot_done_once", done_cnt, 32'd1);

    // Back-to-back fetches of the boot image.
    if_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_addr = AW'(i);
      tick();
      check("if_b2b_valid", {31'h0, if_valid}, 32'd1);
    end
    if_req = 1'b0;
    tick();

    // Store has priority over a simultaneous fetch.
    if_req = 1'b1; if_addr = 8'd3;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'd101; ls_wdata = 16'h0032;
    #1;
    check("prio_if_rdy", {31'h0, if_rdy}, 32'd0);
    tick();
    ls_req = 1'b0; ls_we = 1'b0;
    #1;
    check("prio_if_rdy_next", {31'h0, if_rdy}, 32'd1);
    tick();
    if_req = 1'b0;
    ls_op(1'b0, 8'd101, 16'h0);

    // Out-of-range accesses.
    ls_op(1'b1, 8'd199, 16'h5A5A);
    ls_op(1'b0, 8'd250, 16'h0);
    ls_op(1'b1, 8'd250, 16'hFFFF);
    ls_op(1'b0, 8'd199, 16'h0);
    ls_op(1'b0, 8'd249, 16'h0);
    tick();

    // Reset in the middle of a boot.
    boot_en = 1'b1;
    tick();
    boot_word(16'h1111); boot_word(16'h2222); boot_word(16'h3333);
    model[0] = 16'h1111; model[1] = 16'h2222; model[2] = 16'h3333;
    rst = 1'b1; boot_en = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rst_cnt", {24'h0, boot_cnt}, 32'd0);
    check("mid_rst_done", {31'h0, boot_done}, 32'd0);
    check("mid_rst_run", {31'h0, ls_rdy}, 32'd1);
    if_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_addr = AW'(i);
      tick();
    end
    if_req = 1'b0;
    tick();
    check("mid_rst_no_done", done_cnt, 32'd1);

    // Full boot with boot_en held: writes stop at DEPTH-1, no re-entry.
    boot_en = 1'b1;
    tick();
    for (int i = 0; i < DP + 10; i++) begin
      boot_word(16'hC000 + 16'(i));
      if (i < DP) model[i] = 16'hC000 + 16'(i);
      check("full_done", {31'h0, boot_done}, (i == DP - 1) ? 32'd1 : 32'd0);
      check("full_run", {31'h0, ls_rdy}, (i >= DP) ? 32'd1 : 32'd0);
    end
    check("full_done_once", done_cnt, 32'd2);
    boot_en = 1'b0;
    tick();
    boot_en = 1'b1;
    tick();
    check("reentry", {31'h0, ls_rdy}, 32'd0);
    check("reentry_cnt", {24'h0, boot_cnt}, 32'd0);
    boot_en = 1'b0;
    tick(); tick();
    ls_op(1'b0, 8'd0, 16'h0);
    ls_op(1'b0, 8'd198, 16'h0);
    ls_op(1'b0, 8'd199, 16'h0);
    tick(); tick();
    check("final_done_cnt", done_cnt, 32'd3);
    check("if_q_empty", if_q.size(), 32'd0);
    check("ls_q_empty", ls_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
